puf_challenge_verifier: RTL and testbench

Initiator/verifier side of the ring-oscillator PUF. It issues a sequence of RESP_BITS challenges (select pairs) to the RO PUF core and drives the core's enable/reset for each measurement window. It captures the PUF's single-bit response per challenge, assembles the response word, and compares it with a golden (enrolled) response by Hamming distance. It sits between host/VIO control and the RO PUF core.

---
 rtl/puf_pkg.sv | 35 +++
 rtl/puf_popcount.sv | 24 ++
 rtl/puf_challenge_verifier.sv | 184 ++++++++++++++++++
 tb/tb_puf_challenge_verifier.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/puf_pkg.sv
`default_nettype none
// ============================================================================
// Module      : puf_pkg
// Description : Shared types, defaults and helpers for the RO-PUF verifier.
// Revision    : 1.0 - initial release
// ============================================================================
package puf_pkg;

  // Verifier sequencing states
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PRST = 3'd1,
    ST_MEAS = 3'd2,
    ST_SAMP = 3'd3,
    ST_CMP  = 3'd4,
    ST_DONE = 3'd5
  } state_t;

  localparam int c_sel_w_default  = 4;
  localparam int c_window_default = 4095;

  // Ceiling log2, used to size counters; returns 0 for values <= 1
  function automatic int clog2_f(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) begin
        result = i + 1;
      end
    end
    return result;
  endfunction

endpackage
`default_nettype wire

// File: rtl/puf_popcount.sv
`default_nettype none
// ============================================================================
// Module      : puf_popcount
// Description : Combinational population count of a WIDTH-bit vector.
// Revision    : 1.0 - initial release
// ============================================================================
module puf_popcount #(
  parameter int WIDTH = 16,
  parameter int OUT_W = 5
) (
  input  logic [WIDTH-1:0] i_bits,
  output logic [OUT_W-1:0] o_count
);

  // Sum every set bit of the input vector
  always_comb begin
    o_count = '0;
    for (int i = 0; i < WIDTH; i++) begin
      o_count = o_count + OUT_W'(i_bits[i]);
    end
  end

endmodule
`default_nettype wire

// File: rtl/puf_challenge_verifier.sv
`default_nettype none
// ============================================================================
// Module      : puf_challenge_verifier
// Description : Issues RESP_BITS challenges to an RO PUF core, sequences its
//               reset/enable windows, assembles the response word and
//               compares it with an enrolled golden word by Hamming distance.
// Revision    : 1.0 - initial release
// ============================================================================
module puf_challenge_verifier
  import puf_pkg::*;
#(
  parameter int RESP_BITS  = 16,
  parameter int SEL_W      = c_sel_w_default,
  parameter int WINDOW     = c_window_default,
  parameter int RST_CYC    = 3,
  parameter int SAMPLE_LAT = 2,
  parameter int HD_W       = 5
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 abort,
  input  logic [SEL_W-1:0]     offset,
  input  logic [RESP_BITS-1:0] golden,
  input  logic [HD_W-1:0]      threshold,
  output logic [SEL_W-1:0]     sel_a,
  output logic [SEL_W-1:0]     sel_b,
  output logic                 puf_enable,
  output logic                 puf_reset,
  input  logic                 puf_bit,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [HD_W-1:0]      hd,
  output logic [RESP_BITS-1:0] response
);

  // Counter spans the longest of the three timed phases; it is loaded with
  // (duration - 1) on phase entry and the phase ends when it reaches zero.
  localparam int c_cnt_max = (WINDOW > RST_CYC)
                           ? ((WINDOW > SAMPLE_LAT) ? WINDOW : SAMPLE_LAT)
                           : ((RST_CYC > SAMPLE_LAT) ? RST_CYC : SAMPLE_LAT);
  localparam int c_cnt_w   = (clog2_f(c_cnt_max + 1) < 1) ? 1 : clog2_f(c_cnt_max + 1);
  localparam int c_idx_w   = (clog2_f(RESP_BITS) < 1) ? 1 : clog2_f(RESP_BITS);

  localparam logic [c_cnt_w-1:0] c_rst_load  = c_cnt_w'(RST_CYC - 1);
  localparam logic [c_cnt_w-1:0] c_win_load  = c_cnt_w'(WINDOW - 1);
  localparam logic [c_cnt_w-1:0] c_samp_load = c_cnt_w'(SAMPLE_LAT - 1);
  localparam logic [c_idx_w-1:0] c_last_idx  = c_idx_w'(RESP_BITS - 1);

  state_t                 r_state;
  logic [c_cnt_w-1:0]     r_cnt;
  logic [c_idx_w-1:0]     r_idx;
  logic [RESP_BITS-1:0]   r_golden;
  logic [HD_W-1:0]        r_threshold;
  logic [SEL_W-1:0]       r_offset;

  logic [SEL_W-1:0]       w_offset_eff;
  logic [c_idx_w-1:0]     w_idx_nxt;
  logic [SEL_W-1:0]       w_sel_a_nxt;
  logic [SEL_W-1:0]       w_sel_b_nxt;
  logic [HD_W-1:0]        w_hd;

  // A zero offset would pair an oscillator with itself, so it becomes 1
  assign w_offset_eff = (offset == '0) ? SEL_W'(1) : offset;

  // Challenge pair for the next index; the SEL_W-wide sum wraps naturally
  assign w_idx_nxt   = r_idx + c_idx_w'(1);
  assign w_sel_a_nxt = SEL_W'(w_idx_nxt);
  assign w_sel_b_nxt = w_sel_a_nxt + r_offset;

  puf_popcount #(
    .WIDTH (RESP_BITS),
    .OUT_W (HD_W)
  ) u_popcount (
    .i_bits  (response ^ r_golden),
    .o_count (w_hd)
  );

  // Sequencer: per-challenge reset/measure/sample phases, then compare
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_idx       <= '0;
      r_golden    <= '0;
      r_threshold <= '0;
      r_offset    <= '0;
      sel_a       <= '0;
      sel_b       <= '0;
      puf_enable  <= 1'b0;
      puf_reset   <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      pass        <= 1'b0;
      hd          <= '0;
      response    <= '0;
    end else if (abort && (r_state != ST_IDLE)) begin
      // Abandon the run; the result registers stay in their cleared state
      r_state    <= ST_IDLE;
      sel_a      <= '0;
      sel_b      <= '0;
      puf_enable <= 1'b0;
      puf_reset  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      response   <= '0;
    end else begin
      done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start && !abort) begin
            r_golden    <= golden;
            r_threshold <= threshold;
            r_offset    <= w_offset_eff;
            r_idx       <= '0;
            response    <= '0;
            pass        <= 1'b0;
            busy        <= 1'b1;
            sel_a       <= '0;
            sel_b       <= w_offset_eff;
            puf_reset   <= 1'b1;
            r_cnt       <= c_rst_load;
            r_state     <= ST_PRST;
          end
        end
        ST_PRST: begin
          if (r_cnt == '0) begin
            puf_reset  <= 1'b0;
            puf_enable <= 1'b1;
            r_cnt      <= c_win_load;
            r_state    <= ST_MEAS;
          end else begin
            r_cnt <= r_cnt - c_cnt_w'(1);
          end
        end
        ST_MEAS: begin
          if (r_cnt == '0) begin
            puf_enable <= 1'b0;
            r_cnt      <= c_samp_load;
            r_state    <= ST_SAMP;
          end else begin
            r_cnt <= r_cnt - c_cnt_w'(1);
          end
        end
        ST_SAMP: begin
          if (r_cnt == '0) begin
            response[r_idx] <= puf_bit;
            if (r_idx == c_last_idx) begin
              r_state <= ST_CMP;
            end else begin
              r_idx     <= w_idx_nxt;
              sel_a     <= w_sel_a_nxt;
              sel_b     <= w_sel_b_nxt;
              puf_reset <= 1'b1;
              r_cnt     <= c_rst_load;
              r_state   <= ST_PRST;
            end
          end else begin
            r_cnt <= r_cnt - c_cnt_w'(1);
          end
        end
        ST_CMP: begin
          hd      <= w_hd;
          pass    <= (w_hd <= r_threshold);
          done    <= 1'b1;
          busy    <= 1'b0;
          r_state <= ST_DONE;
        end
        ST_DONE: begin
          sel_a   <= '0;
          sel_b   <= '0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_puf_challenge_verifier.sv
`default_nettype none
// ============================================================================
// Module      : tb_puf_challenge_verifier
// Description : Self-checking bench for puf_challenge_verifier with a
//               cycle-offset reference model and randomized runs.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_puf_challenge_verifier;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int R  = 3;
  localparam int S  = 2;
  localparam int P  = R + W + S;
  localparam int SW = 4;
  localparam int HW = 3;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [SW-1:0] offset = '0;
  logic [N-1:0]  golden = '0;
  logic [HW-1:0] threshold = '0;
  logic [SW-1:0] sel_a, sel_b;
  logic          puf_enable, puf_reset;
  logic          puf_bit = 1'b0;
  logic          busy, done, pass;
  logic [HW-1:0] hd;
  logic [N-1:0]  response;

  puf_challenge_verifier #(
    .RESP_BITS  (N),
    .SEL_W      (SW),
    .WINDOW     (W),
    .RST_CYC    (R),
    .SAMPLE_LAT (S),
    .HD_W       (HW)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .abort      (abort),
    .offset     (offset),
    .golden     (golden),
    .threshold  (threshold),
    .sel_a      (sel_a),
    .sel_b      (sel_b),
    .puf_enable (puf_enable),
    .puf_reset  (puf_reset),
    .puf_bit    (puf_bit),
    .busy       (busy),
    .done       (done),
    .pass       (pass),
    .hd         (hd),
    .response   (response)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Reference model: run flag plus cycle offset k from the accepted start
  bit            m_run  = 0;
  int            m_k    = 0;
  int            m_t0   = 0;
  logic [N-1:0]  m_resp = '0;
  logic [N-1:0]  m_gold = '0;
  logic [HW-1:0] m_thr  = '0;
  logic [HW-1:0] m_hd   = '0;
  logic          m_pass = 1'b0;
  logic [SW-1:0] m_off  = '0;
  logic [N-1:0]  pat    = '0;
  bit            scramble = 0;

  int            n_done   = 0;
  int            done_cyc = 0;
  logic [SW-1:0] selb_b3  = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
    end
  endtask

  // One clock cycle: compare outputs to the model, drive inputs, advance
  task automatic step(input logic st, input logic ab);
    int   b, r;
    logic e_busy, e_done, e_en, e_rst;
    logic [SW-1:0] e_sa, e_sb;
    bit   sel_chk;
    b = 0; r = 0; sel_chk = 1;
    e_busy = 0; e_done = 0; e_en = 0; e_rst = 0; e_sa = '0; e_sb = '0;
    if (m_run && m_k <= N*P) begin
      b = (m_k - 1) / P;
      r = (m_k - 1) % P;
      e_busy = 1;
      e_rst  = (r < R);
      e_en   = (r >= R) && (r < R + W);
      e_sa   = SW'(b % 16);
      e_sb   = SW'((b + int'(m_off)) % 16);
      if (m_k == 3*P + 1) selb_b3 = sel_b;
    end else if (m_run && m_k == N*P + 1) begin
      e_busy = 1; sel_chk = 0;
    end else if (m_run) begin
      e_done = 1; sel_chk = 0;
    end
    chk("busy", busy, e_busy);
    chk("done", done, e_done);
    chk("puf_enable", puf_enable, e_en);
    chk("puf_reset", puf_reset, e_rst);
    if (sel_chk) begin
      chk("sel_a", sel_a, e_sa);
      chk("sel_b", sel_b, e_sb);
    end
    chk("response", response, m_resp);
    chk("hd", hd, m_hd);
    chk("pass", pass, m_pass);
    if (done === 1'b1) begin
      n_done++;
      done_cyc = cyc;
    end

    start = st;
    abort = ab;
    if (m_run && m_k <= N*P && r == P - 1) puf_bit = pat[b];
    else puf_bit = 1'($urandom);
    if (m_run && scramble) begin
      golden    = N'($urandom);
      threshold = HW'($urandom);
      offset    = SW'($urandom);
    end

    if (!m_run) begin
      if (st && !ab) begin
        m_run  = 1; m_k = 1; m_t0 = cyc;
        m_resp = '0; m_pass = 0;
        m_gold = golden; m_thr = threshold;
        m_off  = (offset == '0) ? SW'(1) : offset;
      end
    end else if (ab && m_k <= N*P + 1) begin
      m_run = 0; m_resp = '0; m_pass = 0;
    end else begin
      if (m_k <= N*P && r == P - 1) m_resp[b] = puf_bit;
      if (m_k == N*P + 1) begin
        m_hd   = HW'($countones(m_resp ^ m_gold));
        m_pass = (m_hd <= m_thr);
      end
      if (m_k == N*P + 2) m_run = 0;
      else m_k++;
    end

    @(negedge clock);
    cyc++;
  endtask

  // Start a run and clock it through to idle
  task automatic run(input logic [N-1:0] g, input logic [HW-1:0] t,
                     input logic [SW-1:0] o, input logic [N-1:0] p);
    golden = g; threshold = t; offset = o; pat = p;
    n_done = 0;
    step(1, 0);
    for (int i = 0; i < N*P + 3; i++) step(0, 0);
  endtask

  initial begin
    repeat (2) @(negedge clock);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_en", puf_enable, 0);
    chk("rst_resp", response, 0);
    chk("rst_hd", hd, 0);
    chk("rst_sel_b", sel_b, 0);
    reset = 0;
    @(negedge clock);
    repeat (3) step(0, 0);

    // Golden 1010, PUF gives 1,0,1,0 for index 0..3 -> response 0101, hd 4
    run(4'b1010, 3'd4, 4'd1, 4'b0101);
    chk("run1_resp", response, 4'b0101);
    chk("run1_hd", hd, 4);
    chk("run1_pass", pass, 1);
    chk("run1_latency", done_cyc - m_t0, 54);
    chk("run1_ndone", n_done, 1);

    run(4'b1010, 3'd3, 4'd1, 4'b0101);
    chk("run2_hd", hd, 4);
    chk("run2_pass", pass, 0);

    run(4'b1010, 3'd0, 4'd1, 4'b1010);
    chk("run3_hd", hd, 0);
    chk("run3_pass", pass, 1);

    run(4'b0110, 3'd2, 4'd0, 4'b0011);
    chk("off0_selb_b3", selb_b3, 4);

    run(4'b0110, 3'd2, 4'd15, 4'b0011);
    chk("off15_selb_b3", selb_b3, 2);

    // A second start while busy must be ignored
    golden = 4'b1100; threshold = 3'd1; offset = 4'd3; pat = 4'b1001;
    n_done = 0;
    step(1, 0);
    for (int i = 1; i < 10; i++) step(0, 0);
    step(1, 0);
    for (int i = 0; i < N*P - 6; i++) step(0, 0);
    chk("rebusy_ndone", n_done, 1);
    chk("rebusy_latency", done_cyc - m_t0, 54);

    // Abort in MEAS of bit 1
    golden = 4'b0001; threshold = 3'd4; offset = 4'd2; pat = 4'b1111;
    n_done = 0;
    step(1, 0);
    for (int i = 1; i < 20; i++) step(0, 0);
    step(0, 1);
    chk("abort_busy", busy, 0);
    chk("abort_en", puf_enable, 0);
    chk("abort_resp", response, 0);
    for (int i = 0; i < 40; i++) step(0, 0);
    chk("abort_ndone", n_done, 0);
    run(4'b0001, 3'd4, 4'd2, 4'b0001);
    chk("post_abort_hd", hd, 0);

    // Asynchronous reset between clock edges during MEAS
    golden = 4'b1111; threshold = 3'd1; offset = 4'd5; pat = 4'b0110;
    step(1, 0);
    for (int i = 1; i < 20; i++) step(0, 0);
    #2 reset = 1;
    #1;
    chk("areset_en", puf_enable, 0);
    chk("areset_busy", busy, 0);
    m_run = 0; m_resp = '0; m_hd = '0; m_pass = 0;
    @(negedge clock);
    cyc++;
    reset = 0;
    repeat (2) step(0, 0);
    run(4'b1001, 3'd1, 4'd7, 4'b1000);
    chk("post_rst_hd", hd, 1);

    // Randomized runs with input scrambling, stray starts and aborts
    scramble = 1;
    for (int n = 0; n < 10; n++) begin
      int abort_at;
      golden    = N'($urandom);
      threshold = HW'($urandom);
      offset    = SW'($urandom_range(0, 15));
      pat       = N'($urandom);
      abort_at  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, N*P + 1) : 0;
      step(1, 0);
      for (int i = 0; i < N*P + 3; i++) begin
        step(1'($urandom_range(0, 15) == 0),
             (abort_at != 0) && m_run && (m_k == abort_at));
      end
      scramble = 0;
      repeat (2) step(0, 0);
      scramble = 1;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
